// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Writer side of the instruction-memory interface. A boot link delivers a byte
// stream: [N word count] [4*N payload bytes, little-endian] [checksum byte when
// IMEM_LOADER_CHECKSUM_EN is defined]. Payload bytes are packed into 32-bit
// words and written to instruction memory from byte address 0 upward. The core
// is held in reset until the whole image is in memory.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   defined   -> after the last word a checksum byte (XOR of all payload bytes)
//                is expected; a match finishes the load, a mismatch is an error.
//   undefined -> the last write finishes the load directly.
//
// Parameters
//   D        memory byte-address width; capacity 2**(D-2) words
//   TIMEOUT  max idle cycles between bytes once loading started; 0 disables
//
// Ports
//   i_clk         clock
//   i_reset       synchronous active-high reset
//   i_rx_data     stream byte
//   i_rx_valid    stream byte valid
//   o_rx_ready    loader accepts a byte (transfer = valid & ready)
//   o_mem_addr    word-aligned byte address of the write
//   o_mem_data    write data
//   o_mem_write   one-cycle write strobe
//   o_core_reset  high until the image is loaded
//   o_busy        high while a load is in progress
//   o_done        sticky: image loaded
//   o_error       sticky: bad count, timeout or checksum mismatch
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int D       = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [7:0]   i_rx_data,
    input  logic         i_rx_valid,
    output logic         o_rx_ready,
    output logic [D-1:0] o_mem_addr,
    output logic [31:0]  o_mem_data,
    output logic         o_mem_write,
    output logic         o_core_reset,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_error
);

    localparam int          WI_W = D - 2;
    localparam int unsigned CAP  = 32'd1 << WI_W;
    localparam int          TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [2:0] ST_HEADER  = 3'd0;
    localparam logic [2:0] ST_PAYLOAD = 3'd1;
    localparam logic [2:0] ST_WRITE   = 3'd2;
    localparam logic [2:0] ST_DONE    = 3'd3;
    localparam logic [2:0] ST_ERROR   = 3'd4;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] ST_CHECK   = 3'd5;
`endif

    logic [2:0]      r_state;
    logic [7:0]      r_n;
    logic [WI_W-1:0] r_word_idx;
    logic [1:0]      r_byte_idx;
    logic [23:0]     r_word;
    logic [D-1:0]    r_mem_addr;
    logic [31:0]     r_mem_data;
    logic [TW-1:0]   r_timer;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]      r_csum;
`endif

    logic [2:0]      w_state_next;
    logic            w_rx_ready;
    logic            w_xfer;
    logic            w_n_zero;
    logic            w_n_too_big;
    logic            w_last_word;
    logic            w_timer_hit;

    // Ready depends only on the state, so the source sees a stable handshake.
    always_comb begin
        w_rx_ready = 1'b0;
        case (r_state)
            ST_HEADER:  w_rx_ready = 1'b1;
            ST_PAYLOAD: w_rx_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK:   w_rx_ready = 1'b1;
`endif
            default:    w_rx_ready = 1'b0;
        endcase
    end

    assign w_xfer      = i_rx_valid & w_rx_ready;
    assign w_n_zero    = (i_rx_data == 8'd0);
    assign w_n_too_big = (32'(i_rx_data) > CAP);
    // Compare in 32 bits so word_idx+1 == 2**(D-2) is seen before it wraps.
    assign w_last_word = ((32'(r_word_idx) + 32'd1) == 32'(r_n));
    // Fires on the idle cycle that would bring the counter up to TIMEOUT.
    assign w_timer_hit = (TIMEOUT != 0) &&
                         ((32'(r_timer) + 32'd1) == 32'(TIMEOUT));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_HEADER: begin
                if (w_xfer) begin
                    if (w_n_zero)
                        w_state_next = ST_DONE;
                    else if (w_n_too_big)
                        w_state_next = ST_ERROR;
                    else
                        w_state_next = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (w_xfer) begin
                    if (r_byte_idx == 2'd3)
                        w_state_next = ST_WRITE;
                end else if (w_timer_hit) begin
                    w_state_next = ST_ERROR;
                end
            end
            ST_WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                w_state_next = w_last_word ? ST_CHECK : ST_PAYLOAD;
`else
                w_state_next = w_last_word ? ST_DONE : ST_PAYLOAD;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (w_xfer)
                    w_state_next = (i_rx_data == r_csum) ? ST_DONE : ST_ERROR;
                else if (w_timer_hit)
                    w_state_next = ST_ERROR;
            end
`endif
            ST_DONE:  w_state_next = ST_DONE;
            ST_ERROR: w_state_next = ST_ERROR;
            default:  w_state_next = ST_HEADER;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_HEADER;
            r_n        <= '0;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_word     <= '0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_timer    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum     <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_HEADER: begin
                    if (w_xfer) begin
                        r_n        <= i_rx_data;
                        r_word_idx <= '0;
                        r_byte_idx <= '0;
                        r_timer    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum     <= '0;
`endif
                    end
                end
                ST_PAYLOAD: begin
                    if (w_xfer) begin
                        r_timer    <= '0;
                        r_byte_idx <= r_byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum     <= r_csum ^ i_rx_data;
`endif
                        case (r_byte_idx)
                            2'd0: r_word[7:0]   <= i_rx_data;
                            2'd1: r_word[15:8]  <= i_rx_data;
                            2'd2: r_word[23:16] <= i_rx_data;
                            default: begin
                                // Last byte goes straight into the output
                                // register so the word is ready for WRITE.
                                r_mem_data <= {i_rx_data, r_word};
                                r_mem_addr <= {r_word_idx, 2'b00};
                            end
                        endcase
                    end else if (TIMEOUT != 0) begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_WRITE: begin
                    r_word_idx <= r_word_idx + WI_W'(1);
                    r_timer    <= '0;
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (w_xfer)
                        r_timer <= '0;
                    else if (TIMEOUT != 0)
                        r_timer <= r_timer + TW'(1);
                end
`endif
                default: ;
            endcase
        end
    end

    assign o_rx_ready   = w_rx_ready;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_data   = r_mem_data;
    assign o_mem_write  = (r_state == ST_WRITE);
    assign o_core_reset = (r_state != ST_DONE);
    assign o_done       = (r_state == ST_DONE);
    assign o_error      = (r_state == ST_ERROR);
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign o_busy       = (r_state == ST_PAYLOAD) || (r_state == ST_WRITE) ||
                          (r_state == ST_CHECK);
`else
    assign o_busy       = (r_state == ST_PAYLOAD) || (r_state == ST_WRITE);
`endif

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        o_rx_ready;
    logic [7:0]  o_mem_addr;
    logic [31:0] o_mem_data;
    logic        o_mem_write;
    logic        o_core_reset;
    logic        o_busy;
    logic        o_done;
    logic        o_error;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  q_addr[$];
    logic [31:0] q_data[$];

    imem_loader #(.D(8), .TIMEOUT(16)) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .o_rx_ready   (o_rx_ready),
        .o_mem_addr   (o_mem_addr),
        .o_mem_data   (o_mem_data),
        .o_mem_write  (o_mem_write),
        .o_core_reset (o_core_reset),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_error      (o_error)
    );

    always #5 clk = ~clk;

    // Record every write strobe cycle, sampled just after the edge.
    always @(posedge clk) begin
        #1;
        if (o_mem_write === 1'b1) begin
            q_addr.push_back(o_mem_addr);
            q_data.push_back(o_mem_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        i_reset    = 1'b1;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
        q_addr.delete();
        q_data.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        for (int k = 0; k < 40 && !ok; k++) begin
            if (o_rx_ready === 1'b1) ok = 1'b1;
            @(negedge clk);
        end
        i_rx_valid = 1'b0;
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL send_byte %h: accepted=0 expected 1", b);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (o_rx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", o_rx_ready); end
        n_tests++; if (o_mem_write !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %b expected 0", o_mem_write); end
        n_tests++; if (o_mem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h expected 00", o_mem_addr); end
        n_tests++; if (o_mem_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", o_mem_data); end
        n_tests++; if (o_core_reset !== 1'b1) begin n_fail++; $display("FAIL reset_core_reset: got %b expected 1", o_core_reset); end
        n_tests++; if ({o_busy, o_done, o_error} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {o_busy, o_done, o_error}); end
    endtask

    task automatic test_load_n2();
        do_reset();
        send_byte(8'h02);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        // Now in the write cycle of word 0.
        n_tests++; if (o_mem_write !== 1'b1) begin n_fail++; $display("FAIL load_w0_strobe: got %b expected 1", o_mem_write); end
        n_tests++; if (o_mem_data !== 32'h00000013) begin n_fail++; $display("FAIL load_w0_data: got %h expected 00000013", o_mem_data); end
        n_tests++; if (o_rx_ready !== 1'b0) begin n_fail++; $display("FAIL load_w0_ready: got %b expected 0", o_rx_ready); end
        n_tests++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL load_w0_busy: got %b expected 1", o_busy); end
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        n_tests++; if (o_core_reset !== 1'b1) begin n_fail++; $display("FAIL load_w1_core_reset: got %b expected 1", o_core_reset); end
`ifdef IMEM_LOADER_CHECKSUM_EN
        @(negedge clk);
        n_tests++; if (o_busy !== 1'b1 || o_done !== 1'b0) begin n_fail++; $display("FAIL load_check_state: busy=%b done=%b expected 1 0", o_busy, o_done); end
        send_byte(8'h90);
`else
        @(negedge clk);
`endif
        n_tests++; if (o_core_reset !== 1'b0) begin n_fail++; $display("FAIL load_core_reset_fall: got %b expected 0", o_core_reset); end
        n_tests++; if (o_done !== 1'b1 || o_error !== 1'b0) begin n_fail++; $display("FAIL load_done: done=%b error=%b expected 1 0", o_done, o_error); end
        n_tests++; if (o_rx_ready !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL load_idle: ready=%b busy=%b expected 0 0", o_rx_ready, o_busy); end
        n_tests++; if (q_addr.size() != 2) begin n_fail++; $display("FAIL load_nwrites: got %0d expected 2", q_addr.size()); end
        else begin
            n_tests++; if (q_addr[0] !== 8'h00 || q_data[0] !== 32'h00000013) begin n_fail++; $display("FAIL load_wr0: got %h/%h expected 00/00000013", q_addr[0], q_data[0]); end
            n_tests++; if (q_addr[1] !== 8'h04 || q_data[1] !== 32'h00100093) begin n_fail++; $display("FAIL load_wr1: got %h/%h expected 04/00100093", q_addr[1], q_data[1]); end
        end
    endtask

    task automatic test_n0();
        do_reset();
        send_byte(8'h00);
        n_tests++; if (o_done !== 1'b1) begin n_fail++; $display("FAIL n0_done: got %b expected 1", o_done); end
        n_tests++; if (o_rx_ready !== 1'b0) begin n_fail++; $display("FAIL n0_ready: got %b expected 0", o_rx_ready); end
        n_tests++; if (o_core_reset !== 1'b0) begin n_fail++; $display("FAIL n0_core_reset: got %b expected 0", o_core_reset); end
        // Further bytes are ignored.
        i_rx_data = 8'h55; i_rx_valid = 1'b1;
        repeat (5) @(negedge clk);
        i_rx_valid = 1'b0;
        n_tests++; if (o_done !== 1'b1 || o_error !== 1'b0) begin n_fail++; $display("FAIL n0_sticky: done=%b error=%b expected 1 0", o_done, o_error); end
        n_tests++; if (q_addr.size() != 0) begin n_fail++; $display("FAIL n0_nwrites: got %0d expected 0", q_addr.size()); end
    endtask

    task automatic test_bad_count();
        do_reset();
        send_byte(8'h41);
        n_tests++; if (o_error !== 1'b1 || o_done !== 1'b0) begin n_fail++; $display("FAIL n65_error: error=%b done=%b expected 1 0", o_error, o_done); end
        n_tests++; if (o_core_reset !== 1'b1) begin n_fail++; $display("FAIL n65_core_reset: got %b expected 1", o_core_reset); end
        i_rx_data = 8'h11; i_rx_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            n_tests++; if (o_rx_ready !== 1'b0) begin n_fail++; $display("FAIL n65_ready: got %b expected 0", o_rx_ready); end
        end
        i_rx_valid = 1'b0;
        n_tests++; if (q_addr.size() != 0) begin n_fail++; $display("FAIL n65_nwrites: got %0d expected 0", q_addr.size()); end
        // Exactly full capacity is a legal count.
        do_reset();
        send_byte(8'h40);
        n_tests++; if (o_busy !== 1'b1 || o_error !== 1'b0) begin n_fail++; $display("FAIL n64_accept: busy=%b error=%b expected 1 0", o_busy, o_error); end
    endtask

    task automatic test_timeout();
        do_reset();
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        repeat (15) @(negedge clk);
        n_tests++; if (o_error !== 1'b0 || o_busy !== 1'b1) begin n_fail++; $display("FAIL tmo_early: error=%b busy=%b expected 0 1", o_error, o_busy); end
        @(negedge clk);
        n_tests++; if (o_error !== 1'b1) begin n_fail++; $display("FAIL tmo_error: got %b expected 1", o_error); end
        n_tests++; if (o_core_reset !== 1'b1 || o_busy !== 1'b0) begin n_fail++; $display("FAIL tmo_outputs: core_reset=%b busy=%b expected 1 0", o_core_reset, o_busy); end
        n_tests++; if (q_addr.size() != 0) begin n_fail++; $display("FAIL tmo_nwrites: got %0d expected 0", q_addr.size()); end
        do_reset();
        n_tests++; if (o_rx_ready !== 1'b1 || o_error !== 1'b0) begin n_fail++; $display("FAIL tmo_recover: ready=%b error=%b expected 1 0", o_rx_ready, o_error); end
        // No timeout while waiting for the header.
        repeat (40) @(negedge clk);
        n_tests++; if (o_error !== 1'b0 || o_rx_ready !== 1'b1) begin n_fail++; $display("FAIL tmo_header_wait: error=%b ready=%b expected 0 1", o_error, o_rx_ready); end
    endtask

    task automatic test_reset_midload();
        do_reset();
        send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        n_tests++; if (q_addr.size() != 1) begin n_fail++; $display("FAIL mid_nwrites: got %0d expected 1", q_addr.size()); end
        n_tests++; if (o_mem_data !== 32'h0 || o_mem_addr !== 8'h00) begin n_fail++; $display("FAIL mid_mem_out: got %h/%h expected 00/00000000", o_mem_addr, o_mem_data); end
        n_tests++; if ({o_rx_ready, o_mem_write, o_core_reset, o_busy, o_done, o_error} !== 6'b101000) begin
            n_fail++; $display("FAIL mid_ctrl: got %b expected 101000", {o_rx_ready, o_mem_write, o_core_reset, o_busy, o_done, o_error}); end
        q_addr.delete();
        q_data.delete();
        send_byte(8'h01);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h04);
`else
        @(negedge clk);
`endif
        n_tests++; if (o_done !== 1'b1) begin n_fail++; $display("FAIL mid_reload_done: got %b expected 1", o_done); end
        n_tests++; if (q_addr.size() != 1) begin n_fail++; $display("FAIL mid_reload_nwrites: got %0d expected 1", q_addr.size()); end
        else begin
            n_tests++; if (q_addr[0] !== 8'h00 || q_data[0] !== 32'h04030201) begin n_fail++; $display("FAIL mid_reload_wr: got %h/%h expected 00/04030201", q_addr[0], q_data[0]); end
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        do_reset();
        send_byte(8'h01);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        send_byte(8'h00);
        n_tests++; if (o_done !== 1'b1 || o_error !== 1'b0) begin n_fail++; $display("FAIL csum_good: done=%b error=%b expected 1 0", o_done, o_error); end
        do_reset();
        send_byte(8'h01);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        send_byte(8'h01);
        n_tests++; if (o_error !== 1'b1 || o_done !== 1'b0) begin n_fail++; $display("FAIL csum_bad: error=%b done=%b expected 1 0", o_error, o_done); end
        n_tests++; if (o_core_reset !== 1'b1) begin n_fail++; $display("FAIL csum_bad_core_reset: got %b expected 1", o_core_reset); end
        n_tests++; if (q_data.size() != 1) begin n_fail++; $display("FAIL csum_bad_nwrites: got %0d expected 1", q_data.size()); end
        else begin
            n_tests++; if (q_data[0] !== 32'hDDCCBBAA) begin n_fail++; $display("FAIL csum_bad_wr: got %h expected DDCCBBAA", q_data[0]); end
        end
    endtask
`endif

    initial begin
        i_reset    = 1'b1;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
        @(negedge clk);
        test_reset();
        test_load_n2();
        test_n0();
        test_bad_count();
        test_timeout();
        test_reset_midload();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
